// File: rtl/gpio_pkg.sv
// Shared GPIO constants, also used by the register block, plus a small
// sizing helper for the debounce counter.
package gpio_pkg;

    localparam int GPIO_WIDTH           = 16;
    localparam int GPIO_SYNC_STAGES     = 2;
    localparam int GPIO_DEBOUNCE_CYCLES = 4;

    // Counter must hold 0 .. cycles-1; keep at least one bit for cycles == 1.
    function automatic int gpio_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/gpio_pin_debounce.sv
// One GPIO pin: input synchronizer, debounce counter, stable level and a
// change strobe that is high during the cycle whose closing edge updates the level.
module gpio_pin_debounce
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    output logic stable_level,
    output logic change
);

    localparam int              CNT_W    = gpio_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   stable_r;
    logic                   sync_level_s;
    logic                   mismatch_s;
    logic                   accept_s;

    assign sync_level_s = sync_r[SYNC_STAGES-1];

    // Mismatch detection and acceptance on the last counted cycle.
    always_comb begin
        mismatch_s = sync_level_s ^ stable_r;
        if (mismatch_s && (cnt_r == CNT_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Metastability synchronizer shift chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pin_in};
        end
    end

    // Debounce counter and accepted stable level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= '0;
            stable_r <= sync_level_s;
        end else if (mismatch_s) begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r    <= '0;
        end
    end

    assign stable_level = stable_r;
    assign change       = accept_s;

endmodule

// File: rtl/gpio_pin_if.sv
// GPIO pad interface: pad output muxing, per-pin debounced readback, latched
// edge-event pending bits and a masked interrupt reduction.
module gpio_pin_if
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_pin_in,
    input  logic [WIDTH-1:0] rf_gpio_datareg,
    input  logic [WIDTH-1:0] rf_gpio_tristate,
    input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
    input  logic [WIDTH-1:0] irq_clear,
    output logic [WIDTH-1:0] gpio_pin_out,
    output logic [WIDTH-1:0] gpio_pin_oe,
    output logic [WIDTH-1:0] ro_gpio_pinstate,
    output logic [WIDTH-1:0] irq_pending,
    output logic             irq
);

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] change_s;
    logic [WIDTH-1:0] pending_r;
    logic [WIDTH-1:0] pending_nxt_s;

    assign gpio_pin_out = rf_gpio_datareg;
    assign gpio_pin_oe  = ~rf_gpio_tristate;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_pin_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_pin (
            .clk          (clk),
            .reset        (reset),
            .pin_in       (gpio_pin_in[i]),
            .stable_level (stable_s[i]),
            .change       (change_s[i])
        );
    end

    // Pending next state; a masked event beats a same-cycle clear.
    always_comb begin
        pending_nxt_s = (pending_r & ~irq_clear) | (change_s & rf_gpio_interrupt_mask);
    end

    // Latched per-pin event register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    assign ro_gpio_pinstate = stable_s;
    assign irq_pending      = pending_r;
    assign irq              = |(pending_r & rf_gpio_interrupt_mask);

endmodule

// File: tb/tb_gpio_pin_if.sv
// Scoreboard bench for gpio_pin_if: stimulus queues expected values tagged with
// the clock edge they apply after; a monitor compares them on the falling edge.
module tb_gpio_pin_if;

    localparam int F_PINSTATE = 0;
    localparam int F_PENDING  = 1;
    localparam int F_IRQ      = 2;
    localparam int F_OUT      = 3;
    localparam int F_OE       = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] gpio_pin_in;
    logic [15:0] rf_gpio_datareg;
    logic [15:0] rf_gpio_tristate;
    logic [15:0] rf_gpio_interrupt_mask;
    logic [15:0] irq_clear;
    logic [15:0] gpio_pin_out;
    logic [15:0] gpio_pin_oe;
    logic [15:0] ro_gpio_pinstate;
    logic [15:0] irq_pending;
    logic        irq;

    typedef struct {
        int          at;
        int          field;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    gpio_pin_if dut (
        .clk                    (clk),
        .reset                  (reset),
        .gpio_pin_in            (gpio_pin_in),
        .rf_gpio_datareg        (rf_gpio_datareg),
        .rf_gpio_tristate       (rf_gpio_tristate),
        .rf_gpio_interrupt_mask (rf_gpio_interrupt_mask),
        .irq_clear              (irq_clear),
        .gpio_pin_out           (gpio_pin_out),
        .gpio_pin_oe            (gpio_pin_oe),
        .ro_gpio_pinstate       (ro_gpio_pinstate),
        .irq_pending            (irq_pending),
        .irq                    (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(input int field);
        case (field)
            F_PINSTATE: return ro_gpio_pinstate;
            F_PENDING:  return irq_pending;
            F_IRQ:      return {15'd0, irq};
            F_OUT:      return gpio_pin_out;
            F_OE:       return gpio_pin_oe;
            default:    return 16'hxxxx;
        endcase
    endfunction

    // Monitor: compare every entry due at this edge count.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at <= cyc) begin
                logic [15:0] act;
                act = actual(sb_q[i].field);
                checks++;
                if (act !== sb_q[i].exp) begin
                    failures++;
                    $display("FAIL %s @edge %0d: got %h expected %h",
                             sb_q[i].name, cyc, act, sb_q[i].exp);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int ofs, input int field, input logic [15:0] exp,
                             input string name);
        exp_t e;
        e.at    = cyc + ofs;
        e.field = field;
        e.exp   = exp;
        e.name  = name;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int guard;
        reset                  = 1'b0;
        gpio_pin_in            = 16'hFFFF;
        rf_gpio_datareg        = 16'h1234;
        rf_gpio_tristate       = 16'hFF00;
        rf_gpio_interrupt_mask = 16'h0000;
        irq_clear              = 16'h0000;
        step(1);

        // Reset state with all pads high; pad outputs still follow the registers.
        expect_at(0, F_PINSTATE, 16'h0000, "rst_pinstate");
        expect_at(0, F_PENDING,  16'h0000, "rst_pending");
        expect_at(0, F_IRQ,      16'h0000, "rst_irq");
        expect_at(0, F_OUT,      16'h1234, "pad_out");
        expect_at(0, F_OE,       16'h00FF, "pad_oe");
        step(2);

        // Release: pins already high give a rising edge after 6 edges.
        reset = 1'b1;
        expect_at(5, F_PINSTATE, 16'h0000, "rel_pinstate_e5");
        expect_at(6, F_PINSTATE, 16'hFFFF, "rel_pinstate_e6");
        expect_at(6, F_PENDING,  16'h0000, "rel_pending_unmasked");
        expect_at(6, F_IRQ,      16'h0000, "rel_irq");
        step(8);

        // All pins fall.
        gpio_pin_in = 16'h0000;
        expect_at(5, F_PINSTATE, 16'hFFFF, "fall_pinstate_e5");
        expect_at(6, F_PINSTATE, 16'h0000, "fall_pinstate_e6");
        step(8);

        // Second pad pattern, same cycle.
        rf_gpio_tristate = 16'h0000;
        rf_gpio_datareg  = 16'hABCD;
        expect_at(0, F_OUT, 16'hABCD, "pad_out2");
        expect_at(0, F_OE,  16'hFFFF, "pad_oe2");
        step(1);

        // Three-cycle glitch on pin0 is rejected.
        gpio_pin_in = 16'h0001;
        step(3);
        gpio_pin_in = 16'h0000;
        expect_at(3, F_PINSTATE, 16'h0000, "glitch_pinstate_a");
        expect_at(5, F_PINSTATE, 16'h0000, "glitch_pinstate_b");
        step(8);

        // Masked rise on pin0 sets pending and irq with the pinstate change.
        rf_gpio_interrupt_mask = 16'h0001;
        gpio_pin_in            = 16'h0001;
        expect_at(5, F_PINSTATE, 16'h0000, "rise_pinstate_e5");
        expect_at(5, F_IRQ,      16'h0000, "rise_irq_e5");
        expect_at(6, F_PINSTATE, 16'h0001, "rise_pinstate_e6");
        expect_at(6, F_PENDING,  16'h0001, "rise_pending");
        expect_at(6, F_IRQ,      16'h0001, "rise_irq");
        step(8);

        // Write-1-to-clear.
        irq_clear = 16'h0001;
        expect_at(0, F_PENDING, 16'h0001, "clr_pending_before");
        expect_at(1, F_PENDING, 16'h0000, "clr_pending_after");
        expect_at(1, F_IRQ,     16'h0000, "clr_irq_after");
        step(1);
        irq_clear = 16'h0000;
        step(2);

        // Falling event coincident with a clear: the set wins.
        gpio_pin_in = 16'h0000;
        expect_at(5, F_PINSTATE, 16'h0001, "fallclr_pinstate_e5");
        expect_at(5, F_PENDING,  16'h0000, "fallclr_pending_e5");
        expect_at(6, F_PINSTATE, 16'h0000, "fallclr_pinstate_e6");
        expect_at(6, F_PENDING,  16'h0001, "fallclr_set_wins");
        expect_at(6, F_IRQ,      16'h0001, "fallclr_irq");
        step(5);
        irq_clear = 16'h0001;
        step(1);
        irq_clear = 16'h0000;
        step(2);

        // Mask toggling gates irq without touching pending.
        rf_gpio_interrupt_mask = 16'h0000;
        expect_at(0, F_IRQ,     16'h0000, "mask0_irq");
        expect_at(0, F_PENDING, 16'h0001, "mask0_pending");
        step(1);
        rf_gpio_interrupt_mask = 16'h0001;
        expect_at(0, F_IRQ,     16'h0001, "mask1_irq");
        expect_at(0, F_PENDING, 16'h0001, "mask1_pending");
        step(1);

        // Reset in the middle of a pin5 debounce discards the partial count.
        gpio_pin_in = 16'h0020;
        step(4);
        reset = 1'b0;
        expect_at(0, F_PINSTATE, 16'h0000, "midrst_pinstate");
        expect_at(0, F_PENDING,  16'h0000, "midrst_pending");
        expect_at(0, F_IRQ,      16'h0000, "midrst_irq");
        step(2);
        reset = 1'b1;
        expect_at(5, F_PINSTATE, 16'h0000, "midrst_pinstate_e5");
        expect_at(6, F_PINSTATE, 16'h0020, "midrst_pinstate_e6");
        expect_at(6, F_PENDING,  16'h0000, "midrst_pending_unmasked");
        step(8);

        guard = 0;
        while (sb_q.size() > 0 && guard < 100) begin
            step(1);
            guard++;
        end
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_pin_if.md
GPIO_PIN_IF -- requirements
Module: gpio_pin_if

Interface
REQ-001 Parameter WIDTH, default 16, number of GPIO pins.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth (>=2).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, consecutive cycles a new pin level must persist to be accepted (>=1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 gpio_pin_in  input  WIDTH  raw asynchronous pad levels.
REQ-007 rf_gpio_datareg  input  WIDTH  output data from register block.
REQ-008 rf_gpio_tristate  input  WIDTH  per pin, 1 = tri-stated (input), 0 = driven.
REQ-009 rf_gpio_interrupt_mask  input  WIDTH  per pin, 1 = interrupt enabled.
REQ-010 irq_clear  input  WIDTH  one-cycle write-1-to-clear pulses for irq_pending.
REQ-011 gpio_pin_out  output  WIDTH  pad output data.
REQ-012 gpio_pin_oe  output  WIDTH  pad output enable, 1 = drive.
REQ-013 ro_gpio_pinstate  output  WIDTH  synchronized, debounced pin levels to register block.
REQ-014 irq_pending  output  WIDTH  latched per-pin edge events.
REQ-015 irq  output  1  OR of irq_pending AND rf_gpio_interrupt_mask.

Function
REQ-016 gpio_pin_out SHALL equal rf_gpio_datareg and gpio_pin_oe SHALL equal ~rf_gpio_tristate, combinationally, zero latency.
REQ-017 Each pin SHALL pass through SYNC_STAGES flops before any other use.
REQ-018 Per pin, debounce counter SHALL clear when synchronized level equals stable level, else increment.
REQ-019 Stable level SHALL take the synchronized level on the edge where counter equals DEBOUNCE_CYCLES-1 and mismatch persists; counter clears on that edge.
REQ-020 Pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave stable level unchanged.
REQ-021 ro_gpio_pinstate SHALL be the stable level; total pad-to-pinstate latency SHALL be SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
REQ-022 Pinstate SHALL reflect the pad regardless of direction (driven pins read back).
REQ-023 An event SHALL be any change (rising or falling) of stable level; irq_pending bit SHALL set on the same edge the stable level changes, if the mask bit is 1 at that edge.
REQ-024 irq_clear bit SHALL clear its irq_pending bit on the next edge.
REQ-025 Simultaneous event and clear on the same bit: set SHALL win.
REQ-026 Mask going 0 SHALL NOT clear pending; irq SHALL deassert combinationally and reassert if mask returns while pending.
REQ-027 irq SHALL be derived only from registered pending and mask inputs (no pad path).

Reset
REQ-028 While reset=0: synchronizer flops, stable levels, counters, irq_pending SHALL be 0; ro_gpio_pinstate=0, irq=0.
REQ-029 Reset assertion mid-debounce SHALL discard partial count immediately.
REQ-030 Pins high at reset release SHALL produce a rising event after REQ-021 latency (sets pending only if masked).

Structure
REQ-031 Shared package gpio_pkg SHALL hold GPIO_WIDTH=16 and default SYNC_STAGES, DEBOUNCE_CYCLES constants, shared with the register block.
REQ-032 Sub-module gpio_pin_debounce (one pin: synchronizer, counter, stable level, change pulse) SHALL be instantiated WIDTH times via generate.
REQ-033 Top level SHALL contain pad muxing, pending register, and irq reduction only.

Verification (WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-034 Reset low with gpio_pin_in=16'hFFFF -> all outputs 0 except pad outputs; release with mask 0 -> pinstate=16'hFFFF exactly 6 edges later, irq_pending=0.
REQ-035 rf_gpio_tristate=16'hFF00, rf_gpio_datareg=16'h1234 -> gpio_pin_oe=16'h00FF, gpio_pin_out=16'h1234 same cycle.
REQ-036 Pin0 high 3 cycles then low -> pinstate[0] stays 0; pin0 held high -> pinstate[0]=1 on 6th edge after rise.
REQ-037 Mask=16'h0001, pin0 rises -> irq_pending=16'h0001, irq=1 with pinstate change; irq_clear=16'h0001 pulse -> pending=0, irq=0 next edge.
REQ-038 irq_clear[0] pulsed on the same edge pin0 stable level falls -> irq_pending[0] remains 1.
REQ-039 Pending 16'h0001, mask to 0 -> irq=0, pending held; mask to 1 -> irq=1; reset low mid-debounce on pin5 -> no pinstate[5] change after release until 6 full edges.
